// File: rtl/arm_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : arm_mc_pkg                                             |
// | Description : Shared types and constants for the multicycle core.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package arm_mc_pkg;

  typedef enum logic [0:0] {
    FS_IDLE = 1'b0,
    FS_BUSY = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          WORD_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_unit_if                                          |
// | Description : Instruction memory read port (request/ack handshake).  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface fetch_unit_if;

  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemAck,
    input  MemRData
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemAck,
    output MemRData
  );

endinterface

`default_nettype wire

// File: rtl/prefetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : prefetch_buf                                           |
// | Description : One-entry tagged instruction buffer; exists only when  |
// |               FETCH_PREFETCH_EN is defined.                          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`ifdef FETCH_PREFETCH_EN
module prefetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_tag,
  input  logic [31:0] wr_data,
  input  logic        invalidate,
  output logic [31:0] tag,
  output logic [31:0] data,
  output logic        valid
);

  logic [31:0] r_tag;
  logic [31:0] r_data;
  logic        r_valid;

  // Invalidate outranks a fill so a redirect can never leave stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (invalidate) begin
      r_valid <= 1'b0;
    end else if (wr_en) begin
      r_tag   <= wr_tag;
      r_data  <= wr_data;
      r_valid <= 1'b1;
    end
  end

  assign tag   = r_tag;
  assign data  = r_data;
  assign valid = r_valid;

endmodule
`endif

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_unit                                             |
// | Description : PC register, instruction register and IDLE/BUSY fetch  |
// |               engine. Optional prefetch: FETCH_PREFETCH_EN.          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fetch_unit
  import arm_mc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         PCWrite,
  input  logic [31:0]  PCNext,
  input  logic         IRWrite,
  fetch_unit_if.master mem,
  output logic [31:0]  PC,
  output logic [31:0]  Instr,
  output logic         FetchValid,
  output logic         Stall
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_addr;
  logic         r_valid;
  logic         r_drop;
  logic         r_is_pf;

  logic         w_busy;
  logic         w_want;
  logic         w_demand;
  logic [31:0]  w_pc_word;
  logic         w_buf_hit;
  logic [31:0]  w_buf_data;
  logic         w_pf_issue;
  logic [31:0]  w_pf_addr;

  assign w_busy    = (r_state == FS_BUSY);
  assign w_want    = IRWrite & ~r_valid;
  assign w_demand  = w_want & ~PCWrite;
  assign w_pc_word = word_align(r_pc);

`ifdef FETCH_PREFETCH_EN
  logic        r_pf_pend;
  logic [31:0] r_pf_addr;
  logic [31:0] w_buf_tag;
  logic        w_buf_valid;
  logic        w_cap_hit;
  logic        w_cap_mem;
  logic        w_buf_wr;
  logic        w_buf_inv;

  assign w_cap_hit  = ~w_busy & w_buf_hit & w_demand;
  assign w_cap_mem  = w_busy & mem.MemAck & ~r_drop & ~PCWrite & ~r_is_pf;
  assign w_buf_wr   = w_busy & mem.MemAck & ~r_drop & ~PCWrite & r_is_pf;
  // A redirect onto the buffered address keeps the entry; anything else kills it.
  assign w_buf_inv  = PCWrite & ~(w_buf_valid & (w_buf_tag == word_align(PCNext)));
  assign w_buf_hit  = w_buf_valid & (w_buf_tag == w_pc_word);
  assign w_pf_issue = ~w_busy & r_pf_pend & ~w_want & ~PCWrite;
  assign w_pf_addr  = r_pf_addr;

  prefetch_buf u_prefetch_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (w_buf_wr),
    .wr_tag     (r_addr),
    .wr_data    (mem.MemRData),
    .invalidate (w_buf_inv),
    .tag        (w_buf_tag),
    .data       (w_buf_data),
    .valid      (w_buf_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pf_pend <= 1'b0;
      r_pf_addr <= '0;
    end else if (PCWrite) begin
      r_pf_pend <= 1'b0;
    end else if (w_cap_hit || w_cap_mem) begin
      r_pf_pend <= 1'b1;
      r_pf_addr <= w_pc_word + 32'(WORD_BYTES);
    end else if (w_pf_issue) begin
      r_pf_pend <= 1'b0;
    end
  end
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_data = '0;
  assign w_pf_issue = 1'b0;
  assign w_pf_addr  = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FS_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
      r_is_pf <= 1'b0;
    end else begin
      if (PCWrite) begin
        r_pc    <= PCNext;
        r_valid <= 1'b0;
      end
      case (r_state)
        FS_IDLE: begin
          if (w_demand && w_buf_hit) begin
            r_instr <= w_buf_data;
            r_valid <= 1'b1;
          end else if (w_demand) begin
            r_state <= FS_BUSY;
            r_addr  <= w_pc_word;
            r_drop  <= 1'b0;
            r_is_pf <= 1'b0;
          end else if (w_pf_issue) begin
            r_state <= FS_BUSY;
            r_addr  <= w_pf_addr;
            r_drop  <= 1'b0;
            r_is_pf <= 1'b1;
          end
        end
        FS_BUSY: begin
          // The read stays outstanding after a redirect; its data is dropped on ack.
          if (mem.MemAck) begin
            r_state <= FS_IDLE;
            if (!r_drop && !PCWrite && !r_is_pf) begin
              r_instr <= mem.MemRData;
              r_valid <= 1'b1;
            end
          end else if (PCWrite) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign mem.MemReq  = w_busy;
  assign mem.MemAddr = w_busy ? r_addr : 32'h0000_0000;
  assign PC          = r_pc;
  assign Instr       = r_instr;
  assign FetchValid  = r_valid;
  assign Stall       = IRWrite & ~r_valid;

endmodule

`default_nettype wire
